// File: rtl/toggle_period_meter.sv
// Measures clk cycles between toggles of an asynchronous input, strobes each
// half-period and flags a stalled input. Optional averaging: TOGGLE_PERIOD_AVG_EN.
module toggle_period_meter #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 120_000_000,
  parameter int EDGE_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              stalled,
  output logic [EDGE_W-1:0] edge_count
);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

  state_t              state_q, state_d;
  logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                stalled_q, stalled_d;
  logic [EDGE_W-1:0]   edge_count_q, edge_count_d;
  logic                edge_det;
  logic                meas;
  logic                stall_enter;
  logic [CNT_W-1:0]    raw;

`ifdef TOGGLE_PERIOD_AVG_EN
  logic [CNT_W-1:0]    hist_q [4];
  logic [CNT_W-1:0]    hist_d [4];
  logic [CNT_W+1:0]    sum_q, sum_d;
  logic [2:0]          fill_q, fill_d;
`endif

  // Next-state logic: synchronizer, interval FSM and output updates.
  always_comb begin
    s1_d           = sig_in;
    s2_d           = s1_q;
    s3_d           = s2_q;
    edge_det       = s2_q ^ s3_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;
    meas           = 1'b0;
    stall_enter    = 1'b0;

    if (edge_det) begin
      edge_count_d = edge_count_q + EDGE_ONE;
    end else begin
      edge_count_d = edge_count_q;
    end

    // Saturated counter yields a saturated measurement rather than wrapping to 0.
    if (cnt_q == CNT_MAX) begin
      raw = CNT_MAX;
    end else begin
      raw = cnt_q + CNT_ONE;
    end

    case (state_q)
      ARM: begin
        cnt_d = CNT_ZERO;
        if (edge_det) begin
          state_d = MEASURE;
        end else begin
          state_d = ARM;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          cnt_d = CNT_ZERO;
          meas  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STALL;
          stalled_d   = 1'b1;
          stall_enter = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      STALL: begin
        if (edge_det) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = ARM;
        cnt_d     = CNT_ZERO;
        stalled_d = 1'b0;
      end
    endcase

`ifdef TOGGLE_PERIOD_AVG_EN
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = hist_q[i];
    end
    sum_d  = sum_q;
    fill_d = fill_q;
    if (stall_enter) begin
      for (int i = 0; i < 4; i++) begin
        hist_d[i] = CNT_ZERO;
      end
      sum_d  = {(CNT_W+2){1'b0}};
      fill_d = 3'd0;
    end else if (meas) begin
      // Running sum drops the oldest entry and adds the newest.
      sum_d     = sum_q - {2'b00, hist_q[3]} + {2'b00, raw};
      hist_d[3] = hist_q[2];
      hist_d[2] = hist_q[1];
      hist_d[1] = hist_q[0];
      hist_d[0] = raw;
      if (fill_q >= 3'd3) begin
        fill_d         = 3'd4;
        period_d       = sum_d[CNT_W+1:2];
        period_valid_d = 1'b1;
      end else begin
        fill_d = fill_q + 3'd1;
      end
    end else begin
      sum_d = sum_q;
    end
`else
    if (meas) begin
      period_d       = raw;
      period_valid_d = 1'b1;
    end else begin
      period_d = period_q;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARM;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= CNT_ZERO;
      period_q       <= CNT_ZERO;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      edge_count_q   <= {EDGE_W{1'b0}};
`ifdef TOGGLE_PERIOD_AVG_EN
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= CNT_ZERO;
      end
      sum_q  <= {(CNT_W+2){1'b0}};
      fill_q <= 3'd0;
`endif
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      edge_count_q   <= edge_count_d;
`ifdef TOGGLE_PERIOD_AVG_EN
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
      sum_q  <= sum_d;
      fill_q <= fill_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign edge_count   = edge_count_q;

endmodule
